// File: rtl/odo_fuel_tracker.sv
// Vehicle-state integrator feeding the dashboard LCD: km odometer, fuel burn,
// refuel sequencing and side-brake debounce, all advanced on a slow tick.
module odo_fuel_tracker #(
  parameter int unsigned TICK_DIV     = 500_000,
  parameter int unsigned KM_UNITS     = 360_000,
  parameter int unsigned FUEL_KM      = 5,
  parameter int unsigned FUEL_INIT    = 100,
  parameter int unsigned REFUEL_TICKS = 20,
  parameter int unsigned DEB_TICKS    = 3,
  parameter int unsigned ODO_MAX      = 99_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  speed,
  input  logic        side_brake_sw,
  input  logic        refuel_req,
  output logic [31:0] odometer,
  output logic [7:0]  fuel,
  output logic        is_side_brake,
  output logic        fuel_empty,
  output logic        refueling
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned KM_W   = $clog2(FUEL_KM + 1);
  localparam int unsigned RF_W   = $clog2(REFUEL_TICKS + 1);
  localparam int unsigned DEB_W  = $clog2(DEB_TICKS + 1);
  localparam logic [7:0]  FUEL_FULL = 8'd100;
  localparam logic [7:0]  FUEL_RST  = (FUEL_INIT > 100) ? 8'd100 : 8'(FUEL_INIT);

  typedef enum logic [1:0] {S_DRIVE, S_EMPTY, S_REFUEL} state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]        brake_sync_q, brake_sync_d;
  logic [1:0]        refuel_sync_q, refuel_sync_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              is_side_brake_q, is_side_brake_d;
  logic [19:0]       acc_q, acc_d;
  logic [31:0]       odo_q, odo_d;
  logic [KM_W-1:0]   km_cnt_q, km_cnt_d;
  logic [RF_W-1:0]   rf_cnt_q, rf_cnt_d;
  logic [7:0]        fuel_q, fuel_d;
  logic              fuel_empty_q, fuel_empty_d;

  logic        tick;
  logic        refuel_ok;
  logic [7:0]  eff_speed;
  logic [20:0] acc_sum;
  logic        km_event;

  assign tick      = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign eff_speed = (fuel_q == 8'd0) ? 8'd0 : speed;
  assign refuel_ok = refuel_sync_q[1] && (speed == 8'd0) && is_side_brake_q
                     && (fuel_q < FUEL_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_DRIVE;
      tick_cnt_q      <= '0;
      brake_sync_q    <= '0;
      refuel_sync_q   <= '0;
      deb_cnt_q       <= '0;
      is_side_brake_q <= 1'b0;
      acc_q           <= '0;
      odo_q           <= '0;
      km_cnt_q        <= '0;
      rf_cnt_q        <= '0;
      fuel_q          <= FUEL_RST;
      fuel_empty_q    <= (FUEL_RST == 8'd0);
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      brake_sync_q    <= brake_sync_d;
      refuel_sync_q   <= refuel_sync_d;
      deb_cnt_q       <= deb_cnt_d;
      is_side_brake_q <= is_side_brake_d;
      acc_q           <= acc_d;
      odo_q           <= odo_d;
      km_cnt_q        <= km_cnt_d;
      rf_cnt_q        <= rf_cnt_d;
      fuel_q          <= fuel_d;
      fuel_empty_q    <= fuel_empty_d;
    end
  end

  always_comb begin
    tick_cnt_d      = tick ? '0 : tick_cnt_q + 1'b1;
    brake_sync_d    = {brake_sync_q[0], side_brake_sw};
    refuel_sync_d   = {refuel_sync_q[0], refuel_req};
    deb_cnt_d       = deb_cnt_q;
    is_side_brake_d = is_side_brake_q;
    acc_d           = acc_q;
    acc_sum         = {1'b0, acc_q} + {13'd0, eff_speed};
    km_event        = 1'b0;
    odo_d           = odo_q;
    km_cnt_d        = km_cnt_q;
    fuel_d          = fuel_q;
    if (tick) begin
      if (brake_sync_q[1] == is_side_brake_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_W'(DEB_TICKS - 1)) begin
        is_side_brake_d = brake_sync_q[1];
        deb_cnt_d       = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
      // Distance integrates only while driving; at most one km per tick.
      if (state_q == S_DRIVE) begin
        if (acc_sum >= 21'(KM_UNITS)) begin
          acc_d    = 20'(acc_sum - 21'(KM_UNITS));
          km_event = 1'b1;
        end else begin
          acc_d = acc_sum[19:0];
        end
      end
      if (km_event) begin
        odo_d = (odo_q == ODO_MAX) ? 32'd0 : odo_q + 32'd1;
        if (km_cnt_q == KM_W'(FUEL_KM - 1)) begin
          km_cnt_d = '0;
          fuel_d   = (fuel_q != 8'd0) ? fuel_q - 8'd1 : 8'd0;
        end else begin
          km_cnt_d = km_cnt_q + 1'b1;
        end
      end
      if (state_q == S_REFUEL && rf_cnt_q == RF_W'(REFUEL_TICKS - 1)
          && fuel_q < FUEL_FULL) begin
        fuel_d = fuel_q + 8'd1;
      end
    end
    fuel_empty_d = (fuel_d == 8'd0);
  end

  // Kept apart from the datapath block so it can depend on state_d without a loop.
  always_comb begin
    rf_cnt_d = rf_cnt_q;
    if (state_d != S_REFUEL) begin
      rf_cnt_d = '0;
    end else if (tick) begin
      rf_cnt_d = (rf_cnt_q == RF_W'(REFUEL_TICKS - 1)) ? '0 : rf_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_DRIVE: begin
          if (refuel_ok)           state_d = S_REFUEL;
          else if (fuel_d == 8'd0) state_d = S_EMPTY;
        end
        S_EMPTY: begin
          if (refuel_ok) state_d = S_REFUEL;
        end
        S_REFUEL: begin
          if (!refuel_sync_q[1] || !is_side_brake_q || speed != 8'd0
              || fuel_d == FUEL_FULL) begin
            state_d = S_DRIVE;
          end
        end
        default: state_d = S_DRIVE;
      endcase
    end
  end

  always_comb begin
    refueling = (state_q == S_REFUEL);
  end

  assign odometer      = odo_q;
  assign fuel          = fuel_q;
  assign is_side_brake = is_side_brake_q;
  assign fuel_empty    = fuel_empty_q;

endmodule

// File: tb/tb_odo_fuel_tracker.sv
// Directed bench for odo_fuel_tracker with a short tick; a second instance
// with a tiny odometer range exercises the wrap point.
module tb_odo_fuel_tracker;

  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  speed = 8'd0;
  logic        side_brake_sw = 1'b0;
  logic        refuel_req = 1'b0;
  logic [31:0] odometer;
  logic [7:0]  fuel;
  logic        is_side_brake, fuel_empty, refueling;

  logic [7:0]  speed_w = 8'd0;
  logic        sw_w = 1'b0;
  logic        req_w = 1'b0;
  logic [31:0] odometer_w;
  logic [7:0]  fuel_w;
  logic        is_side_brake_w, fuel_empty_w, refueling_w;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  odo_fuel_tracker #(
    .TICK_DIV(4), .KM_UNITS(100), .FUEL_KM(2), .FUEL_INIT(10),
    .REFUEL_TICKS(3), .DEB_TICKS(2), .ODO_MAX(99_999)
  ) dut (
    .clk(clk), .rst(rst), .speed(speed), .side_brake_sw(side_brake_sw),
    .refuel_req(refuel_req), .odometer(odometer), .fuel(fuel),
    .is_side_brake(is_side_brake), .fuel_empty(fuel_empty), .refueling(refueling)
  );

  odo_fuel_tracker #(
    .TICK_DIV(4), .KM_UNITS(100), .FUEL_KM(2), .FUEL_INIT(100),
    .REFUEL_TICKS(3), .DEB_TICKS(2), .ODO_MAX(3)
  ) dut_wrap (
    .clk(clk), .rst(rst), .speed(speed_w), .side_brake_sw(sw_w),
    .refuel_req(req_w), .odometer(odometer_w), .fuel(fuel_w),
    .is_side_brake(is_side_brake_w), .fuel_empty(fuel_empty_w), .refueling(refueling_w)
  );

  task automatic tick_wait(input int n);
    repeat (n * TDIV) @(negedge clk);
  endtask

  task automatic wait_refueling(input string name);
    int waited = 0;
    while (refueling !== 1'b1 && waited < 4) begin
      tick_wait(1);
      waited++;
    end
    total++;
    if (refueling !== 1'b1) begin
      bad++;
      $display("FAIL %s: refueling never rose, got %b want 1", name, refueling);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (odometer !== 32'd0) begin bad++; $display("FAIL rst_odo: got %0d want 0", odometer); end
    total++; if (fuel !== 8'd10) begin bad++; $display("FAIL rst_fuel: got %0d want 10", fuel); end
    total++; if (is_side_brake !== 1'b0 || fuel_empty !== 1'b0 || refueling !== 1'b0) begin
      bad++; $display("FAIL rst_flags: got sb=%b fe=%b rf=%b want 0 0 0", is_side_brake, fuel_empty, refueling);
    end
    total++; if (fuel_w !== 8'd100) begin bad++; $display("FAIL rst_fuel_w: got %0d want 100", fuel_w); end
    rst = 1'b0;
  endtask

  task automatic test_distance;
    speed = 8'd50;
    tick_wait(2);
    total++; if (odometer !== 32'd1 || fuel !== 8'd10) begin
      bad++; $display("FAIL dist_2t: got odo=%0d fuel=%0d want 1 10", odometer, fuel);
    end
    tick_wait(2);
    total++; if (odometer !== 32'd2 || fuel !== 8'd9) begin
      bad++; $display("FAIL dist_4t: got odo=%0d fuel=%0d want 2 9", odometer, fuel);
    end
    tick_wait(4);
    total++; if (odometer !== 32'd4 || fuel !== 8'd8) begin
      bad++; $display("FAIL dist_8t: got odo=%0d fuel=%0d want 4 8", odometer, fuel);
    end
    speed = 8'd0;
    tick_wait(3);
    total++; if (odometer !== 32'd4 || fuel !== 8'd8) begin
      bad++; $display("FAIL dist_stop: got odo=%0d fuel=%0d want 4 8", odometer, fuel);
    end
  endtask

  task automatic test_debounce;
    side_brake_sw = 1'b1;
    tick_wait(1);
    total++; if (is_side_brake !== 1'b0) begin bad++; $display("FAIL deb_pulse_hi: got %b want 0", is_side_brake); end
    side_brake_sw = 1'b0;
    tick_wait(2);
    total++; if (is_side_brake !== 1'b0) begin bad++; $display("FAIL deb_pulse_lo: got %b want 0", is_side_brake); end
    side_brake_sw = 1'b1;
    tick_wait(1);
    total++; if (is_side_brake !== 1'b0) begin bad++; $display("FAIL deb_hold_1: got %b want 0", is_side_brake); end
    tick_wait(1);
    total++; if (is_side_brake !== 1'b1) begin bad++; $display("FAIL deb_hold_2: got %b want 1", is_side_brake); end
  endtask

  task automatic test_run_to_empty;
    speed = 8'd100;
    tick_wait(15);
    total++; if (odometer !== 32'd19 || fuel !== 8'd1 || fuel_empty !== 1'b0) begin
      bad++; $display("FAIL empty_pre: got odo=%0d fuel=%0d fe=%b want 19 1 0", odometer, fuel, fuel_empty);
    end
    tick_wait(1);
    total++; if (odometer !== 32'd20 || fuel !== 8'd0 || fuel_empty !== 1'b1) begin
      bad++; $display("FAIL empty_hit: got odo=%0d fuel=%0d fe=%b want 20 0 1", odometer, fuel, fuel_empty);
    end
    tick_wait(5);
    total++; if (odometer !== 32'd20 || fuel !== 8'd0) begin
      bad++; $display("FAIL empty_frozen: got odo=%0d fuel=%0d want 20 0", odometer, fuel);
    end
  endtask

  task automatic test_refuel;
    speed = 8'd0;
    refuel_req = 1'b1;
    wait_refueling("refuel_enter");
    total++; if (fuel !== 8'd0 || fuel_empty !== 1'b1) begin
      bad++; $display("FAIL refuel_start: got fuel=%0d fe=%b want 0 1", fuel, fuel_empty);
    end
    tick_wait(3);
    total++; if (fuel !== 8'd1 || fuel_empty !== 1'b0) begin
      bad++; $display("FAIL refuel_first: got fuel=%0d fe=%b want 1 0", fuel, fuel_empty);
    end
    tick_wait(27);
    total++; if (fuel !== 8'd10 || refueling !== 1'b1) begin
      bad++; $display("FAIL refuel_30t: got fuel=%0d rf=%b want 10 1", fuel, refueling);
    end
    refuel_req = 1'b0;
    tick_wait(1);
    total++; if (refueling !== 1'b0 || fuel !== 8'd10 || fuel_empty !== 1'b0) begin
      bad++; $display("FAIL refuel_exit: got rf=%b fuel=%0d fe=%b want 0 10 0", refueling, fuel, fuel_empty);
    end
    speed = 8'd5;
    refuel_req = 1'b1;
    tick_wait(4);
    total++; if (refueling !== 1'b0 || fuel !== 8'd10 || odometer !== 32'd20) begin
      bad++; $display("FAIL refuel_moving: got rf=%b fuel=%0d odo=%0d want 0 10 20", refueling, fuel, odometer);
    end
  endtask

  task automatic test_odo_wrap;
    speed_w = 8'd100;
    tick_wait(2);
    total++; if (odometer_w !== 32'd2) begin bad++; $display("FAIL wrap_pre: got %0d want 2", odometer_w); end
    tick_wait(1);
    total++; if (odometer_w !== 32'd3) begin bad++; $display("FAIL wrap_max: got %0d want 3", odometer_w); end
    tick_wait(1);
    total++; if (odometer_w !== 32'd0 || fuel_w !== 8'd98) begin
      bad++; $display("FAIL wrap_zero: got odo=%0d fuel=%0d want 0 98", odometer_w, fuel_w);
    end
    speed_w = 8'd0;
  endtask

  task automatic test_reset_mid_refuel;
    speed = 8'd100;
    tick_wait(10);
    total++; if (odometer !== 32'd30 || fuel !== 8'd5 || refueling !== 1'b0) begin
      bad++; $display("FAIL mid_drive: got odo=%0d fuel=%0d rf=%b want 30 5 0", odometer, fuel, refueling);
    end
    speed = 8'd0;
    wait_refueling("mid_enter");
    tick_wait(1);
    total++; if (fuel !== 8'd5) begin bad++; $display("FAIL mid_fuel: got %0d want 5", fuel); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (fuel !== 8'd10 || odometer !== 32'd0) begin
      bad++; $display("FAIL mid_rst_vals: got fuel=%0d odo=%0d want 10 0", fuel, odometer);
    end
    total++; if (refueling !== 1'b0 || is_side_brake !== 1'b0 || fuel_empty !== 1'b0) begin
      bad++; $display("FAIL mid_rst_flags: got rf=%b sb=%b fe=%b want 0 0 0", refueling, is_side_brake, fuel_empty);
    end
    @(negedge clk);
    rst = 1'b0;
    tick_wait(1);
    total++; if (refueling !== 1'b0 || is_side_brake !== 1'b0) begin
      bad++; $display("FAIL mid_after: got rf=%b sb=%b want 0 0", refueling, is_side_brake);
    end
  endtask

  initial begin
    test_reset();
    test_distance();
    test_debounce();
    test_run_to_empty();
    test_refuel();
    test_odo_wrap();
    test_reset_mid_refuel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
